acc_decoder: RTL

Recovers the per-cycle 3-bit step values from the 5-bit running-sum stream produced by the accumulator datapath, where the sum restarts at 0 on every zero step. It is the inverse of that accumulator: it sits on the consumer side of the sum bus, takes one sample per valid cycle, and emits the step value. It also tracks the segment length, flags samples that no legal step sequence could produce, and resynchronises on the next zero sample.

---
 rtl/acc_decoder.sv | 112 +++++++++++
 1 files changed

// File: rtl/acc_decoder.sv
// Inverse of the zero-restarting step accumulator: turns a 5-bit running-sum
// stream back into 3-bit steps, tracking segment length and lock/error status.
module acc_decoder (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [4:0] in_sum,
  output logic       out_valid,
  output logic [2:0] step,
  output logic       seg_start,
  output logic       err,
  output logic [3:0] seg_len,
  output logic [7:0] err_cnt,
  output logic       locked
);

  // Handshake: valid-only streaming. in_valid qualifies in_sum for one cycle
  // and cannot be refused; out_valid qualifies step/seg_start/err one cycle
  // later. There is no ready in either direction.

  typedef enum logic {SYNC = 1'b0, RUN = 1'b1} state_t;

  state_t     state, state_nxt;
  logic [4:0] prev, prev_nxt;
  logic [4:0] diff;
  logic       legal;

  logic       out_valid_nxt;
  logic [2:0] step_nxt;
  logic       seg_start_nxt;
  logic       err_nxt;
  logic [3:0] seg_len_nxt;
  logic [7:0] err_cnt_nxt;

  // Wrapping subtract lets a sum that rolled past 31 still decode correctly.
  assign diff  = in_sum - prev;
  assign legal = (diff != 5'd0) && (diff[4:3] == 2'b00);

  // State register plus the registered outputs and datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= SYNC;
      prev      <= 5'd0;
      out_valid <= 1'b0;
      step      <= 3'd0;
      seg_start <= 1'b0;
      err       <= 1'b0;
      seg_len   <= 4'd0;
      err_cnt   <= 8'd0;
    end else begin
      state     <= state_nxt;
      prev      <= prev_nxt;
      out_valid <= out_valid_nxt;
      step      <= step_nxt;
      seg_start <= seg_start_nxt;
      err       <= err_nxt;
      seg_len   <= seg_len_nxt;
      err_cnt   <= err_cnt_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    if (in_valid) begin
      case (state)
        SYNC:    if (in_sum == 5'd0) state_nxt = RUN;
        RUN:     if (in_sum != 5'd0 && !legal) state_nxt = SYNC;
        default: state_nxt = SYNC;
      endcase
    end
  end

  // Output/datapath decode; anything not touched holds its registered value
  always_comb begin
    out_valid_nxt = 1'b0;
    step_nxt      = step;
    seg_start_nxt = seg_start;
    err_nxt       = err;
    seg_len_nxt   = seg_len;
    err_cnt_nxt   = err_cnt;
    prev_nxt      = prev;
    if (in_valid) begin
      if (in_sum == 5'd0) begin
        out_valid_nxt = 1'b1;
        step_nxt      = 3'd0;
        seg_start_nxt = 1'b1;
        err_nxt       = 1'b0;
        seg_len_nxt   = 4'd0;
        prev_nxt      = 5'd0;
      end else if (state == RUN) begin
        out_valid_nxt = 1'b1;
        seg_start_nxt = 1'b0;
        if (legal) begin
          step_nxt    = diff[2:0];
          err_nxt     = 1'b0;
          prev_nxt    = in_sum;
          seg_len_nxt = (seg_len == 4'd15) ? seg_len : seg_len + 4'd1;
        end else begin
          step_nxt    = 3'd0;
          err_nxt     = 1'b1;
          err_cnt_nxt = (err_cnt == 8'd255) ? err_cnt : err_cnt + 8'd1;
          seg_len_nxt = 4'd0;
          prev_nxt    = 5'd0;
        end
      end
    end
  end

  assign locked = (state == RUN);

endmodule
